qd1_stimulus_out: RTL and testbench

Avalon-MM slave peripheral that generates a programmable pulse train on a single output pin. It is the drive-side counterpart of the edge-capturing stimulus input port. Software either sets a static level or launches a burst of N square pulses (or a continuous train) with a programmable half-period. Completion is latched in a done flag and can raise a maskable interrupt.

---
 rtl/qd1_stimulus_out_pkg.sv | 27 ++
 rtl/qd1_stimulus_out_timer.sv | 38 +++
 rtl/qd1_stimulus_out.sv | 191 +++++++++++++++++++
 tb/tb_qd1_stimulus_out.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qd1_stimulus_out_pkg.sv
// Shared definitions for the stimulus output port: register map, bit positions, FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (Avalon-MM slave never stalls).
package qd1_stimulus_out_pkg;

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_PERIOD  = 3'd1;
    localparam logic [2:0] ADDR_COUNT   = 3'd2;
    localparam logic [2:0] ADDR_IRQMASK = 3'd3;
    localparam logic [2:0] ADDR_STATUS  = 3'd4;
    localparam logic [2:0] ADDR_CONTROL = 3'd5;

    localparam int CTRL_START   = 0;
    localparam int CTRL_CONT    = 1;
    localparam int CTRL_STOP    = 2;

    localparam int STAT_DONE    = 0;
    localparam int STAT_BUSY    = 1;
    localparam int STAT_REM_LSB = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/qd1_stimulus_out_timer.sv
// Loadable down-counter timing each half-period; tc flags a count of exactly 1.
// Latency: load/decrement visible the cycle after the edge; tc is combinational from the count.
// Backpressure: none; load has priority over enable, counter holds at 0.
// Ports: clk, reset_n (sync, active-low), load, en, load_val[PER_W-1:0], tc.
module qd1_stimulus_out_timer #(
    parameter int PER_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic             en,
    input  logic [PER_W-1:0] load_val,
    output logic             tc
);

    logic [PER_W-1:0] cnt_q;
    logic [PER_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - PER_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = (cnt_q == PER_W'(1));

endmodule

// File: rtl/qd1_stimulus_out.sv
// Avalon-MM pulse-train generator: static level or N (or endless) square pulses of half-period P.
// Latency: readdata 1 cycle; out_port high from the 2nd edge after a start write (registered start).
// Backpressure: none; start while busy is ignored, stop wins over start.
// Ports: clk, reset_n, address/chipselect/write_n/writedata/readdata (Avalon-MM), irq, out_port.
module qd1_stimulus_out
    import qd1_stimulus_out_pkg::*;
#(
    parameter int PER_W = 16,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq,
    output logic        out_port
);

    state_t           state_q, state_d;
    logic             data_reg_q, data_reg_d;
    logic [PER_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] pcount_q, pcount_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             irq_mask_q, irq_mask_d;
    logic             done_q, done_d;
    logic             cont_q, cont_d;
    logic             start_q, start_d;
    logic             out_port_q, out_port_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             wr_en, ctrl_wr, stop_req, start_req, done_set;
    logic             tmr_load, tmr_en, tmr_tc;
    logic [PER_W-1:0] per_eff;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    qd1_stimulus_out_timer #(.PER_W(PER_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load),
        .en       (tmr_en),
        .load_val (per_eff),
        .tc       (tmr_tc)
    );

    always_comb begin
        wr_en     = chipselect & ~write_n;
        ctrl_wr   = wr_en && (address == ADDR_CONTROL);
        stop_req  = ctrl_wr && writedata[CTRL_STOP];
        // A pending start counts as busy so a second start cannot re-latch cont.
        start_req = ctrl_wr && writedata[CTRL_START] && !writedata[CTRL_STOP]
                    && (state_q == IDLE) && !start_q;
        per_eff   = (period_q == '0) ? PER_W'(1) : period_q;

        state_d     = state_q;
        data_reg_d  = data_reg_q;
        period_d    = period_q;
        pcount_d    = pcount_q;
        remaining_d = remaining_q;
        irq_mask_d  = irq_mask_q;
        done_d      = done_q;
        cont_d      = cont_q;
        start_d     = start_req;
        done_set    = 1'b0;
        tmr_load    = 1'b0;
        tmr_en      = (state_q != IDLE);

        if (wr_en) begin
            case (address)
                ADDR_DATA:    data_reg_d = writedata[0];
                ADDR_PERIOD:  period_d   = writedata[PER_W-1:0];
                ADDR_COUNT:   pcount_d   = writedata[CNT_W-1:0];
                ADDR_IRQMASK: irq_mask_d = writedata[0];
                default: ;
            endcase
        end
        if (start_req) begin
            cont_d = writedata[CTRL_CONT];
        end

        // The start write is registered for one cycle so that the state change
        // and the out_port change land on the same edge (out_port follows state_d).
        case (state_q)
            IDLE: begin
                if (start_q && !stop_req) begin
                    if ((pcount_q == '0) && !cont_q) begin
                        done_set = 1'b1;
                    end else begin
                        state_d     = HIGH;
                        remaining_d = pcount_q;
                        tmr_load    = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (stop_req) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end else if (tmr_tc) begin
                    state_d  = LOW;
                    tmr_load = 1'b1;
                end
            end
            LOW: begin
                if (stop_req) begin
                    state_d  = IDLE;
                    done_set = 1'b1;
                end else if (tmr_tc) begin
                    if (cont_q) begin
                        state_d  = HIGH;
                        tmr_load = 1'b1;
                    end else if (remaining_q == CNT_W'(1)) begin
                        state_d  = IDLE;
                        done_set = 1'b1;
                    end else begin
                        state_d     = HIGH;
                        remaining_d = remaining_q - CNT_W'(1);
                        tmr_load    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear first so a simultaneous completion still leaves done set.
        if (wr_en && (address == ADDR_STATUS)) begin
            done_d = 1'b0;
        end
        if (done_set) begin
            done_d = 1'b1;
        end

        case (state_d)
            HIGH:    out_port_d = 1'b1;
            LOW:     out_port_d = 1'b0;
            default: out_port_d = data_reg_q;
        endcase

        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[0]         = data_reg_q;
            ADDR_PERIOD:  readdata_d[PER_W-1:0] = period_q;
            ADDR_COUNT:   readdata_d[CNT_W-1:0] = pcount_q;
            ADDR_IRQMASK: readdata_d[0]         = irq_mask_q;
            ADDR_STATUS: begin
                readdata_d[STAT_DONE]                           = done_q;
                readdata_d[STAT_BUSY]                           = (state_q != IDLE);
                readdata_d[CNT_W+STAT_REM_LSB-1:STAT_REM_LSB]   = remaining_q;
            end
            ADDR_CONTROL: readdata_d[CTRL_CONT] = cont_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            data_reg_q  <= 1'b0;
            period_q    <= '0;
            pcount_q    <= '0;
            remaining_q <= '0;
            irq_mask_q  <= 1'b0;
            done_q      <= 1'b0;
            cont_q      <= 1'b0;
            start_q     <= 1'b0;
            out_port_q  <= 1'b0;
            readdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            data_reg_q  <= data_reg_d;
            period_q    <= period_d;
            pcount_q    <= pcount_d;
            remaining_q <= remaining_d;
            irq_mask_q  <= irq_mask_d;
            done_q      <= done_d;
            cont_q      <= cont_d;
            start_q     <= start_d;
            out_port_q  <= out_port_d;
            readdata_q  <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = out_port_q;
    assign irq      = done_q & irq_mask_q;

endmodule

// File: tb/tb_qd1_stimulus_out.sv
// Self-checking bench for qd1_stimulus_out: expected out_port/irq per cycle and
// expected readdata per read are queued when stimulus is driven, popped as the DUT responds.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled there too.
module tb_qd1_stimulus_out;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        irq;
    logic        out_port;

    typedef struct packed {
        logic out;
        logic irq;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rd_q[$];
    int          errors = 0;
    int          checks = 0;

    qd1_stimulus_out dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic rd_issue(input logic [2:0] a);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
    endtask

    // Drains the per-cycle expectation queue, comparing out_port and irq each cycle.
    task automatic run_pattern(input string name);
        exp_t e;
        while (exp_q.size() > 0) begin
            tick();
            e = exp_q.pop_front();
            checks++;
            if (out_port !== e.out) begin
                errors++;
                $display("FAIL %s out_port: got %b expected %b", name, out_port, e.out);
            end
            checks++;
            if (irq !== e.irq) begin
                errors++;
                $display("FAIL %s irq: got %b expected %b", name, irq, e.irq);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] e;
        reset_n = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
        checks++;
        if (out_port !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got out=%b irq=%b expected 0 0", out_port, irq);
        end
        for (int a = 0; a < 8; a++) begin
            rd_q.push_back(32'h0);
            rd_issue(3'(a));
            e = rd_q.pop_front();
            checks++;
            if (readdata !== e) begin
                errors++;
                $display("FAIL reset_read[%0d]: got %h expected %h", a, readdata, e);
            end
        end
    endtask

    task automatic test_data();
        logic [31:0] e;
        wr(3'd0, 32'h1);
        exp_q.push_back('{out: 1'b1, irq: 1'b0});
        run_pattern("data_level");
        rd_q.push_back(32'h1);
        rd_issue(3'd0);
        e = rd_q.pop_front();
        checks++;
        if (readdata !== e) begin
            errors++;
            $display("FAIL data_read: got %h expected %h", readdata, e);
        end
    endtask

    task automatic test_burst();
        logic pat [12] = '{1, 1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0};
        wr(3'd1, 32'd3);
        wr(3'd2, 32'd2);
        wr(3'd3, 32'd1);
        wr(3'd5, 32'd1);
        for (int i = 0; i < 12; i++) exp_q.push_back('{out: pat[i], irq: 1'b0});
        exp_q.push_back('{out: 1'b1, irq: 1'b1});
        run_pattern("burst_p3_n2");
        wr(3'd4, 32'h0);
        checks++;
        if (irq !== 1'b0) begin
            errors++;
            $display("FAIL burst_irq_clear: got %b expected 0", irq);
        end
    endtask

    task automatic test_min_period();
        wr(3'd1, 32'd0);
        wr(3'd2, 32'd1);
        wr(3'd5, 32'd1);
        exp_q.push_back('{out: 1'b1, irq: 1'b0});
        exp_q.push_back('{out: 1'b0, irq: 1'b0});
        exp_q.push_back('{out: 1'b1, irq: 1'b1});
        run_pattern("period_zero");
        wr(3'd4, 32'h0);
    endtask

    task automatic test_continuous();
        exp_t        e;
        logic [31:0] er;
        wr(3'd1, 32'd2);
        wr(3'd5, 32'd3);
        address = 3'd4;
        for (int i = 0; i < 100; i++) begin
            exp_q.push_back('{out: ((i % 4) < 2), irq: 1'b0});
            // remaining stays 1 from the previous burst; busy once the pending start is taken
            rd_q.push_back((i == 0) ? 32'h4 : 32'h6);
            tick();
            e  = exp_q.pop_front();
            er = rd_q.pop_front();
            checks++;
            if (out_port !== e.out) begin
                errors++;
                $display("FAIL cont_out[%0d]: got %b expected %b", i, out_port, e.out);
            end
            checks++;
            if (readdata !== er) begin
                errors++;
                $display("FAIL cont_status[%0d]: got %h expected %h", i, readdata, er);
            end
        end
        wr(3'd5, 32'd4);
        checks++;
        if (out_port !== 1'b1 || irq !== 1'b1) begin
            errors++;
            $display("FAIL cont_stop: got out=%b irq=%b expected 1 1", out_port, irq);
        end
        rd_q.push_back(32'h5);
        rd_issue(3'd4);
        er = rd_q.pop_front();
        checks++;
        if (readdata !== er) begin
            errors++;
            $display("FAIL cont_stop_status: got %h expected %h", readdata, er);
        end
        rd_q.push_back(32'h2);
        rd_issue(3'd5);
        er = rd_q.pop_front();
        checks++;
        if (readdata !== er) begin
            errors++;
            $display("FAIL cont_ctrl_read: got %h expected %h", readdata, er);
        end
        wr(3'd4, 32'h0);
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        logic [31:0] er;
        logic        pat [5] = '{1, 0, 1, 0, 1};
        wr(3'd1, 32'd1);
        wr(3'd2, 32'd2);
        wr(3'd5, 32'd1);
        for (int i = 0; i < 5; i++) exp_q.push_back('{out: pat[i], irq: (i == 4)});
        exp_q.push_back('{out: 1'b1, irq: 1'b1});
        exp_q.push_back('{out: 1'b1, irq: 1'b1});
        tick();
        e = exp_q.pop_front();
        checks++;
        if (out_port !== e.out) begin
            errors++;
            $display("FAIL b2b_first: got %b expected %b", out_port, e.out);
        end
        // continuous start issued mid-burst must be ignored
        address    = 3'd5;
        writedata  = 32'd3;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (out_port !== e.out) begin
            errors++;
            $display("FAIL b2b_second: got %b expected %b", out_port, e.out);
        end
        run_pattern("b2b_rest");
        rd_q.push_back(32'h0);
        rd_issue(3'd5);
        er = rd_q.pop_front();
        checks++;
        if (readdata !== er) begin
            errors++;
            $display("FAIL b2b_cont: got %h expected %h", readdata, er);
        end
        wr(3'd4, 32'h0);
    endtask

    task automatic test_reset_mid();
        logic [31:0] er;
        wr(3'd1, 32'd3);
        wr(3'd2, 32'd2);
        wr(3'd5, 32'd1);
        repeat (4) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        checks++;
        if (out_port !== 1'b0 || irq !== 1'b0) begin
            errors++;
            $display("FAIL midreset_out: got out=%b irq=%b expected 0 0", out_port, irq);
        end
        for (int a = 0; a < 5; a++) begin
            rd_q.push_back(32'h0);
            rd_issue(3'(a));
            er = rd_q.pop_front();
            checks++;
            if (readdata !== er) begin
                errors++;
                $display("FAIL midreset_read[%0d]: got %h expected %h", a, readdata, er);
            end
        end
    endtask

    task automatic test_count_zero();
        logic [31:0] er;
        wr(3'd3, 32'd1);
        wr(3'd1, 32'd2);
        wr(3'd5, 32'd1);
        repeat (4) exp_q.push_back('{out: 1'b0, irq: 1'b1});
        run_pattern("count_zero");
        rd_q.push_back(32'h1);
        rd_issue(3'd4);
        er = rd_q.pop_front();
        checks++;
        if (readdata !== er) begin
            errors++;
            $display("FAIL count_zero_status: got %h expected %h", readdata, er);
        end
        wr(3'd4, 32'h0);
    endtask

    task automatic test_start_stop();
        logic [31:0] er;
        wr(3'd2, 32'd2);
        wr(3'd5, 32'd5);
        repeat (6) exp_q.push_back('{out: 1'b0, irq: 1'b0});
        run_pattern("start_stop");
        rd_q.push_back(32'h0);
        rd_issue(3'd4);
        er = rd_q.pop_front();
        checks++;
        if (readdata !== er) begin
            errors++;
            $display("FAIL start_stop_status: got %h expected %h", readdata, er);
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        test_reset();
        test_data();
        test_burst();
        test_min_period();
        test_continuous();
        test_back_to_back();
        test_reset_mid();
        test_count_zero();
        test_start_stop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
